ecc_decode_stream: RTL
======================

Name: ecc_decode_stream

Overview:
- Streaming SECDED decoder for extended Hamming codewords, with a valid/ready handshake.
- Sits directly downstream of the memory/link that stores ECC-encoded data; consumes codewords sized by ecc_pkg::get_parity_width / get_cw_width.
- Corrects single-bit errors and flags double-bit errors.
- Registers the result in one pipeline stage, keeps saturating error counters and sticky status for the scrubber/CSR block.

Parameters:
- DataWidth, 32, payload bits per codeword (>=1).
- CntWidth, 16, width of each saturating error counter (>=1).
- ParWidth, ecc_pkg::get_parity_width(DataWidth), Hamming parity bits (derived, not overridden).
- CwWidth, DataWidth+ParWidth, Hamming word width (derived; input is CwWidth+1 bits).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  async active-low reset
- in_valid_i  in  1  codeword valid
- in_ready_o  out  1  decoder can accept
- in_cw_i  in  CwWidth+1  [CwWidth] = overall parity; [CwWidth-1:0] = Hamming word, bit k = position k+1
- out_valid_o  out  1  result valid
- out_ready_i  in  1  consumer accepts
- out_data_o  out  DataWidth  corrected data
- out_single_err_o  out  1  beat had a correctable error
- out_double_err_o  out  1  beat had an uncorrectable error
- clear_i  in  1  synchronous clear of counters and sticky flags
- single_cnt_o  out  CntWidth  saturating single-error count
- double_cnt_o  out  CntWidth  saturating double-error count
- sticky_single_o  out  1  any single error since clear
- sticky_double_o  out  1  any double error since clear

Behaviour:
- Reset (async, rst_ni=0): all outputs and registers 0. in_ready_o = 1 after reset.
- Code layout:
  - Parity bits sit at positions 2^i, i=0..ParWidth-1.
  - Data fills the remaining positions in ascending order, LSB first.
- Decode (combinational, on in_cw_i):
  - Syndrome s = XOR of positions p (1-based) of all set bits in the Hamming word.
  - Overall parity e = XOR of all CwWidth+1 bits.
- Classification:
  - s=0, e=0 → clean.
  - e=1, s=0 → overall-parity bit flipped. single_err=1, data unchanged.
  - e=1, 1<=s<=CwWidth → flip bit s, single_err=1.
  - e=1, s>CwWidth → double_err=1, no correction.
  - e=0, s!=0 → double_err=1, data = uncorrected extraction.
  - single_err and double_err are never both 1.
- Pipeline:
  - One output register; latency 1 cycle from the accepting edge to out_valid_o.
  - in_ready_o = !out_valid_q || out_ready_i, so full throughput: 1 beat/cycle under continuous ready.
  - Register loads on in_valid_i && in_ready_o.
  - out_valid_q clears on out_ready_i without a new accept.
  - While out_valid_o=1 && out_ready_i=0, out_data_o and both error flags hold stable.
  - in_cw_i is ignored when in_valid_i=0.
- Counters and sticky flags:
  - Update on accepted beats only, in the accept cycle (not at the output).
  - Counters saturate at 2^CntWidth-1 and never wrap.
  - Sticky flags set on the matching event.
  - clear_i together with an event in the same cycle: counter = 1 and sticky = 1; the event is not lost.
  - clear_i without an event: counter = 0, sticky = 0.
  - clear_i does not affect the data pipeline.
- Reset mid-stream: the in-flight beat is dropped and out_valid_o goes to 0 immediately, asynchronously.

Decomposition:
- Additions to ecc_pkg:
  - Function is_pow2(pos).
  - Function hamming_pos_of_data(idx), returning the Hamming position of data bit idx.
  - typedef ecc_status_e {ECC_CLEAN, ECC_SINGLE, ECC_DOUBLE}.
- Sub-module ecc_sat_counter (CntWidth; inc_i, clr_i, cnt_o), instantiated twice.
- Syndrome/correct logic stays inline.

Test Plan (DataWidth=32 → ParWidth=6, CwWidth=38, input 39 bits):
- Encode 0xDEADBEEF cleanly, in_valid=1, out_ready=1 → next cycle out_data=0xDEADBEEF, both err=0, counters 0.
- Same codeword with Hamming bit at position 5 flipped → out_data=0xDEADBEEF, single_err=1; single_cnt=1, sticky_single=1.
- Flip positions 3 and 9 → double_err=1, single_err=0; double_cnt=1. Flip only bit [38] → single_err=1, data correct.
- Accept beat A, hold out_ready=0 for 3 cycles while in_valid=1 with beat B:
  - in_ready=0 throughout; out_data=A stable.
  - Raise ready → A consumed, B appears next cycle. No loss or duplication.
- CntWidth=2, inject 5 single errors → single_cnt=3 (saturated). Then clear_i together with a double-error beat → single_cnt=0, double_cnt=1, sticky_double=1, sticky_single=0.
- Assert rst_ni=0 while out_valid=1 → out_valid, counters and sticky flags read 0 in the same cycle; in_ready=1 after release.

Source files
------------

// File: rtl/ecc_pkg.sv
// Shared SECDED helpers: code geometry, position mapping and status encoding.
// Pure package: functions, types and constants only, no logic and no latency.
// Backpressure: not applicable, there is no handshake here.
package ecc_pkg;

    typedef enum logic [1:0] {
        ECC_CLEAN  = 2'd0,
        ECC_SINGLE = 2'd1,
        ECC_DOUBLE = 2'd2
    } ecc_status_e;

    // Smallest p such that 2^p can address every Hamming position plus zero.
    function automatic int get_parity_width(int data_width);
        int p;
        p = 1;
        while ((1 << p) < data_width + p + 1) begin
            p++;
        end
        return p;
    endfunction

    function automatic int get_cw_width(int data_width);
        return data_width + get_parity_width(data_width);
    endfunction

    function automatic bit is_pow2(int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    // Data bits occupy the non power-of-two positions in ascending order.
    // idx+40 positions always suffice: fewer than 40 parity slots fit below.
    function automatic int hamming_pos_of_data(int idx);
        int cnt;
        cnt = 0;
        for (int p = 1; p <= idx + 40; p++) begin
            if (!is_pow2(p)) begin
                if (cnt == idx) begin
                    return p;
                end
                cnt++;
            end
        end
        return 0;
    endfunction

endpackage

// File: rtl/ecc_sat_counter.sv
// Saturating event counter with a synchronous clear that keeps a same-cycle event.
// Latency: count visible one cycle after the increment/clear edge.
// Backpressure: none; counts every cycle inc_i is high and holds at all-ones.
module ecc_sat_counter #(
    parameter int CntWidth = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                inc_i,
    input  logic                clr_i,
    output logic [CntWidth-1:0] cnt_o
);

    logic [CntWidth-1:0] cnt_q;

    // Clear wins over the old value but not over an event arriving with it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= inc_i ? CntWidth'(1) : '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CntWidth'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ecc_decode_stream.sv
// Streaming SECDED decoder: corrects single-bit errors, flags double-bit errors.
// Latency: 1 cycle from the accepting edge to out_valid_o, 1 beat/cycle sustained.
// Backpressure: in_ready_o drops only while a held result is not being taken.
module ecc_decode_stream
    import ecc_pkg::*;
#(
    parameter  int DataWidth = 32,
    parameter  int CntWidth  = 16,
    localparam int ParWidth  = get_parity_width(DataWidth),
    localparam int CwWidth   = DataWidth + ParWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [CwWidth:0]     in_cw_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DataWidth-1:0] out_data_o,
    output logic                 out_single_err_o,
    output logic                 out_double_err_o,
    input  logic                 clear_i,
    output logic [CntWidth-1:0]  single_cnt_o,
    output logic [CntWidth-1:0]  double_cnt_o,
    output logic                 sticky_single_o,
    output logic                 sticky_double_o
);

    logic [CwWidth-1:0]   ham_word;
    logic [CwWidth-1:0]   corr_word;
    logic [ParWidth-1:0]  syndrome;
    logic                 overall_par;
    ecc_status_e          status;
    logic [DataWidth-1:0] dec_data;
    logic                 accept;
    logic                 ev_single;
    logic                 ev_double;

    logic                 out_valid_q;
    logic [DataWidth-1:0] out_data_q;
    logic                 out_single_q;
    logic                 out_double_q;
    logic                 sticky_single_q;
    logic                 sticky_double_q;

    assign ham_word    = in_cw_i[CwWidth-1:0];
    assign overall_par = ^in_cw_i;

    // Syndrome is the XOR of the 1-based positions of every set Hamming bit.
    always_comb begin
        syndrome = '0;
        for (int k = 0; k < CwWidth; k++) begin
            if (ham_word[k]) begin
                syndrome = syndrome ^ ParWidth'(k + 1);
            end
        end
    end

    // A zero syndrome with odd parity means only the overall parity bit flipped;
    // a syndrome pointing past the word can only come from a multi-bit error.
    always_comb begin
        if (syndrome == '0) begin
            status = overall_par ? ECC_SINGLE : ECC_CLEAN;
        end else if (!overall_par) begin
            status = ECC_DOUBLE;
        end else if (int'(syndrome) <= CwWidth) begin
            status = ECC_SINGLE;
        end else begin
            status = ECC_DOUBLE;
        end
    end

    // Flip the bit the syndrome names; a zero syndrome matches no position.
    always_comb begin
        corr_word = ham_word;
        if (status == ECC_SINGLE) begin
            for (int k = 0; k < CwWidth; k++) begin
                if (syndrome == ParWidth'(k + 1)) begin
                    corr_word[k] = ~ham_word[k];
                end
            end
        end
    end

    for (genvar g = 0; g < DataWidth; g++) begin : g_extract
        localparam int Pos = hamming_pos_of_data(g);
        assign dec_data[g] = corr_word[Pos-1];
    end

    assign in_ready_o = !out_valid_q || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;
    assign ev_single  = accept && (status == ECC_SINGLE);
    assign ev_double  = accept && (status == ECC_DOUBLE);

    // Single output stage; payload and flags only move on an accept so they
    // stay frozen while the consumer stalls.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_single_q <= 1'b0;
            out_double_q <= 1'b0;
        end else if (accept) begin
            out_valid_q  <= 1'b1;
            out_data_q   <= dec_data;
            out_single_q <= (status == ECC_SINGLE);
            out_double_q <= (status == ECC_DOUBLE);
        end else if (out_ready_i) begin
            out_valid_q  <= 1'b0;
        end
    end

    // Sticky status follows the counters: a same-cycle event survives a clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sticky_single_q <= 1'b0;
            sticky_double_q <= 1'b0;
        end else if (clear_i) begin
            sticky_single_q <= ev_single;
            sticky_double_q <= ev_double;
        end else begin
            sticky_single_q <= sticky_single_q | ev_single;
            sticky_double_q <= sticky_double_q | ev_double;
        end
    end

    ecc_sat_counter #(.CntWidth(CntWidth)) u_single_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (ev_single),
        .clr_i  (clear_i),
        .cnt_o  (single_cnt_o)
    );

    ecc_sat_counter #(.CntWidth(CntWidth)) u_double_cnt (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .inc_i  (ev_double),
        .clr_i  (clear_i),
        .cnt_o  (double_cnt_o)
    );

    assign out_valid_o      = out_valid_q;
    assign out_data_o       = out_data_q;
    assign out_single_err_o = out_single_q;
    assign out_double_err_o = out_double_q;
    assign sticky_single_o  = sticky_single_q;
    assign sticky_double_o  = sticky_double_q;

endmodule
